lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Load/store unit between the ALU and the data memory.
- Accepts one load or store per handshake: the ALU byte address, funct_3 and rs2 store data.
- Drives a word-aligned request/acknowledge memory port with byte enables.
- Returns the sign- or zero-extended load value for rd, plus an error flag.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUSY without mem_ack before the access is abandoned with an error; legal range 1..1023.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents an access
- req_ready  output  1  unit can accept an access
- req_op  input  7  opcode; `OP_LD (0000011) or `OP_ST (0100011)
- req_funct_3  input  3  LB/LH/LW/LBU/LHU or SB/SH/SW
- req_addr  input  32  byte address from ALU out
- req_wdata  input  32  rs2 value for stores
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  extended load value; 0 for stores and errors
- resp_err  output  1  qualifies resp_valid: illegal access or timeout
- mem_req  output  1  memory request, held until acknowledged
- mem_we  output  1  1 = write
- mem_addr  output  32  {req_addr[31:2], 2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  read word, valid with mem_ack
- mem_ack  input  1  memory completes the access this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0 except req_ready=1. All mem_* outputs drop immediately, including mid-access.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - req_ready=1. Accept on req_valid && req_ready at an edge; latch op, funct_3, addr[1:0] and the memory fields.
  - Legal access -> BUSY. Illegal op/funct_3 -> DONE with err=1, no memory request.
- BUSY:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata stay constant.
  - Timeout counter clears on entry and increments each cycle.
  - mem_ack sampled high -> capture mem_rdata, go to DONE.
  - Counter reaching TIMEOUT_CYCLES with no ack -> go to DONE with err=1.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins.
- DONE: resp_valid=1 for exactly one cycle, req_ready=0, then back to IDLE.
- Latency: accepted at edge N -> mem_req high in cycle N+1 -> ack at edge M (M >= N+1) -> resp_valid in cycle M+1 -> next accept earliest at edge M+2.
- mem_ack outside BUSY is ignored.
- Store lanes, with off = addr[1:0]:
  - SB: be = 0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<off, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Load extraction from captured rdata:
  - LB/LBU: byte off, sign- or zero-extended.
  - LH/LHU: halfword off[1], sign- or zero-extended.
  - LW: full word.
  - Loads drive be=1111.
- Illegal accesses:
  - Load funct_3 011, 110 or 111.
  - Store funct_3 >= 011.
  - Any other opcode.
- resp_data holds its value between pulses and is 0 on err.

Optional Feature:
- Macro: LSU_MISALIGN_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1 is misaligned, as is LW/SW with addr[1:0]!=00.
  - A misaligned access issues no memory request, goes IDLE->DONE with resp_err=1, and asserts an extra output port misaligned (1 bit) alongside resp_valid.
- Undefined:
  - No misaligned port; the offset is forced to natural alignment.
  - Halfword accesses use off = {addr[1], 0}; word accesses use off = 00.
  - The access proceeds normally with no error.

Test Plan:
- LB at addr 0x1003, mem_rdata 0x80FF_1234 acked 1 cycle after req -> mem_addr 0x1000, be=1111, resp_data 0xFFFF_FF80, resp_err=0, resp_valid 3 cycles after accept.
- SH at addr 0x2002, rs2 0xDEAD_BEEF -> mem_we=1, be=1100, mem_wdata 0xBEEF_BEEF, resp_data 0.
- LHU at addr 0x0, mem_ack held low 5 cycles, rdata 0x0000_8001 -> mem_req stable for 6 cycles, resp_data 0x0000_8001.
- LW, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, resp_err=1, resp_data 0; a stray ack next cycle is ignored.
- Load funct_3=011 -> no mem_req, resp_valid+resp_err in the cycle after accept. rst_n pulsed low mid-BUSY -> mem_req=0 immediately, req_ready=1.
- SW at addr 0x3001: with LSU_MISALIGN_EN -> misaligned=1, resp_err=1, no mem_req. Without it -> be=1111, mem_addr 0x3000, no error.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit between the ALU and a word-aligned request/acknowledge data memory port.
// Build macro LSU_MISALIGN_EN rejects misaligned half/word accesses and adds a 'misaligned' output.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_op,
    input  logic [2:0]  req_funct_3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
`ifdef LSU_MISALIGN_EN
    output logic        misaligned,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic        is_load;
    logic        is_store;
    logic        legal;
    logic        mis;
    logic        accept;
    logic [1:0]  off;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;

    logic [9:0]  cnt_q;
    logic        timeout_hit;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic        err_q;
`ifdef LSU_MISALIGN_EN
    logic        mis_q;
`endif

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Request decode: legality, lane offset, byte enables and replicated store data.
    always_comb begin
        is_load  = (req_op == OP_LD);
        is_store = (req_op == OP_ST);
        legal    = 1'b0;
        if (is_load) begin
            legal = (req_funct_3 != 3'b011) && (req_funct_3 != 3'b110) &&
                    (req_funct_3 != 3'b111);
        end else if (is_store) begin
            legal = (req_funct_3 < 3'b011);
        end

        case (req_funct_3[1:0])
            2'b00:   off = req_addr[1:0];
            2'b01:   off = {req_addr[1], 1'b0};
            default: off = 2'b00;
        endcase

        mis = 1'b0;
`ifdef LSU_MISALIGN_EN
        mis = legal && (((req_funct_3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct_3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`endif

        be_n    = 4'b1111;
        wdata_n = req_wdata;
        if (is_store) begin
            case (req_funct_3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << off;
                    wdata_n = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_n    = 4'b0011 << off;
                    wdata_n = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = req_wdata;
                end
            endcase
        end
    end

    assign accept      = req_valid && (state_q == IDLE);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is checked ahead of the timeout so a late ack on the final cycle still completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (legal && !mis) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mem_ack || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load extraction from the word returned by memory, using the latched lane offset.
    always_comb begin
        case (off_q)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            off_q     <= '0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            resp_data <= '0;
`ifdef LSU_MISALIGN_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q   <= '0;
                        we_q    <= is_store;
                        addr_q  <= req_addr[31:2];
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        size_q  <= req_funct_3[1:0];
                        off_q   <= off;
                        uns_q   <= req_funct_3[2];
                        err_q   <= !legal || mis;
`ifdef LSU_MISALIGN_EN
                        mis_q   <= mis;
`endif
                        if (!legal || mis) begin
                            resp_data <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        resp_data <= we_q ? 32'd0 : load_val;
                        err_q     <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data <= '0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory fields are only presented while a request is outstanding.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_err   = (state_q == DONE) && err_q;
    assign mem_req    = (state_q == BUSY);
    assign mem_we     = mem_req && we_q;
    assign mem_addr   = mem_req ? {addr_q, 2'b00} : 32'd0;
    assign mem_be     = mem_req ? be_q : 4'd0;
    assign mem_wdata  = mem_req ? wdata_q : 32'd0;
`ifdef LSU_MISALIGN_EN
    assign misaligned = (state_q == DONE) && mis_q;
`endif

endmodule
